// File: rtl/reset_sequencer_pkg.sv
// ============================================================================
// reset_sequencer_pkg : state encodings, reset-cause codes, 40 MHz timing defaults
// Revision: 1.0
// ============================================================================
`default_nettype none

package reset_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_POR_WAIT  = 3'd0,
        ST_LOCK_WAIT = 3'd1,
        ST_STRETCH   = 3'd2,
        ST_HOLD      = 3'd3,
        ST_RUN       = 3'd4
    } state_t;

    localparam logic [1:0] CAUSE_POR    = 2'b00;
    localparam logic [1:0] CAUSE_LOCK   = 2'b01;
    localparam logic [1:0] CAUSE_BUTTON = 2'b10;
    localparam logic [1:0] CAUSE_SW     = 2'b11;

    localparam int unsigned DEF_POR_CYCLES       = 400000;
    localparam int unsigned DEF_DEBOUNCE_CYCLES  = 200000;
    localparam int unsigned DEF_MIN_PULSE_CYCLES = 4000;
    localparam int unsigned DEF_CNT_W            = 20;

endpackage

`default_nettype wire

// File: rtl/reset_sequencer_if.sv
// ============================================================================
// reset_sequencer_if : reset sources in, reset request and status out
// Revision: 1.0
// ============================================================================
`default_nettype none

interface reset_sequencer_if;
    logic       pll_locked;
    logic       button_n;
    logic       sw_reset_req;
    logic       reset_out_n;
    logic [1:0] reset_cause;
    logic       reset_active;

    modport master (
        output pll_locked, button_n, sw_reset_req,
        input  reset_out_n, reset_cause, reset_active
    );

    modport slave (
        input  pll_locked, button_n, sw_reset_req,
        output reset_out_n, reset_cause, reset_active
    );
endinterface

`default_nettype wire

// File: rtl/reset_sequencer_sync_debounce.sv
// ============================================================================
// sync_debounce : 2-flop synchroniser with optional consecutive-stable debounce
// Revision: 1.0
// ============================================================================
`default_nettype none

module sync_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 8,
    parameter int unsigned CNT_W           = 20,
    parameter logic        RESET_VAL       = 1'b0,
    parameter bit          BYPASS          = 1'b0
) (
    input  wire logic clock,
    input  wire logic reset_n,
    input  wire logic i_d,
    output logic      o_q
);

    logic r_s1;
    logic r_s2;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_s1 <= RESET_VAL;
            r_s2 <= RESET_VAL;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
        end
    end

    generate
        if (BYPASS) begin : g_bypass
            assign o_q = r_s2;
        end else begin : g_debounce
            localparam logic [CNT_W-1:0] C_DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

            logic [CNT_W-1:0] r_cnt;
            logic             r_db;

            // Output flips only after the input has disagreed for DEBOUNCE_CYCLES clocks in a row
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    r_cnt <= '0;
                    r_db  <= RESET_VAL;
                end else if (r_s2 == r_db) begin
                    r_cnt <= '0;
                end else if (r_cnt == C_DB_LAST) begin
                    r_cnt <= '0;
                    r_db  <= r_s2;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            assign o_q = r_db;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/reset_sequencer.sv
// ============================================================================
// reset_sequencer : merges POR, PLL lock, pushbutton and software reset into
// one minimum-width active-low reset request. Optional macro RESET_SEQ_SW_REQ_EN
// enables the software reset request. Revision: 1.0
// ============================================================================
`default_nettype none

module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int unsigned POR_CYCLES       = DEF_POR_CYCLES,
    parameter int unsigned DEBOUNCE_CYCLES  = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned MIN_PULSE_CYCLES = DEF_MIN_PULSE_CYCLES,
    parameter int unsigned CNT_W            = DEF_CNT_W
) (
    input  wire logic         clock,
    input  wire logic         reset_n,
    reset_sequencer_if.slave  bus
);

    localparam logic [CNT_W-1:0] C_POR_LAST = CNT_W'(POR_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_MIN_LAST = CNT_W'(MIN_PULSE_CYCLES - 1);

    logic w_lock_s;
    logic w_btn_db;
    logic w_btn_press;
    logic w_sw_req;

    sync_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W),
        .RESET_VAL       (1'b0),
        .BYPASS          (1'b1)
    ) u_lock_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .i_d     (bus.pll_locked),
        .o_q     (w_lock_s)
    );

    sync_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W),
        .RESET_VAL       (1'b1),
        .BYPASS          (1'b0)
    ) u_btn_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .i_d     (bus.button_n),
        .o_q     (w_btn_db)
    );

    assign w_btn_press = ~w_btn_db;

`ifdef RESET_SEQ_SW_REQ_EN
    assign w_sw_req = bus.sw_reset_req;
`else
    logic w_sw_unused;
    assign w_sw_unused = bus.sw_reset_req;
    assign w_sw_req    = 1'b0;
`endif

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             w_cnt_clr;
    logic [1:0]       r_cause;
    logic [1:0]       w_cause_next;
    logic             r_out_n;

    always_comb begin
        w_next       = r_state;
        w_cnt_clr    = 1'b0;
        w_cause_next = r_cause;
        case (r_state)
            ST_POR_WAIT: begin
                if (r_cnt == C_POR_LAST) w_next = ST_LOCK_WAIT;
            end
            ST_LOCK_WAIT: begin
                if (w_lock_s) w_next = ST_STRETCH;
            end
            ST_STRETCH: begin
                if (!w_lock_s)               w_next    = ST_LOCK_WAIT;
                else if (w_btn_press)        w_next    = ST_HOLD;
                else if (w_sw_req)           w_cnt_clr = 1'b1;
                else if (r_cnt == C_MIN_LAST) w_next   = ST_RUN;
            end
            ST_HOLD: begin
                if (!w_lock_s)         w_next = ST_LOCK_WAIT;
                else if (!w_btn_press) w_next = ST_STRETCH;
            end
            ST_RUN: begin
                if (!w_lock_s) begin
                    w_next       = ST_LOCK_WAIT;
                    w_cause_next = CAUSE_LOCK;
                end else if (w_btn_press) begin
                    w_next       = ST_HOLD;
                    w_cause_next = CAUSE_BUTTON;
                end else if (w_sw_req) begin
                    w_next       = ST_STRETCH;
                    w_cause_next = CAUSE_SW;
                end
            end
            default: w_next = ST_POR_WAIT;
        endcase
    end

    // Count only in the timed states; any state change or restart clears it
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_POR_WAIT;
            r_cnt   <= '0;
            r_cause <= CAUSE_POR;
            r_out_n <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cause <= w_cause_next;
            r_out_n <= (w_next == ST_RUN);
            if ((w_next != r_state) || w_cnt_clr)
                r_cnt <= '0;
            else if ((r_state == ST_POR_WAIT) || (r_state == ST_STRETCH))
                r_cnt <= r_cnt + 1'b1;
        end
    end

    assign bus.reset_out_n  = r_out_n;
    assign bus.reset_active = ~r_out_n;
    assign bus.reset_cause  = r_cause;

endmodule

`default_nettype wire

// File: tb/tb_reset_sequencer.sv
// ============================================================================
// tb_reset_sequencer : directed scoreboard bench for reset_sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_reset_sequencer;
    import reset_sequencer_pkg::*;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    reset_sequencer_if bus();

    reset_sequencer #(
        .POR_CYCLES       (16),
        .DEBOUNCE_CYCLES  (8),
        .MIN_PULSE_CYCLES (4),
        .CNT_W            (8)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int base  = 0;
    int total = 0;
    int bad   = 0;

    typedef struct {
        int         at;
        logic       out_n;
        logic [1:0] cause;
        string      tag;
    } exp_t;

    exp_t sb[$];

    task automatic push(input string tag, input int at, input logic o, input logic [1:0] c);
        exp_t e;
        e.tag = tag; e.at = at; e.out_n = o; e.cause = c;
        sb.push_back(e);
    endtask

    task automatic check_now(input string tag, input logic o, input logic [1:0] c);
        logic [3:0] got;
        logic [3:0] want;
        got  = {bus.reset_out_n, bus.reset_active, bus.reset_cause};
        want = {o, ~o, c};
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: observed out_n/active/cause=%b expected=%b", tag, got, want);
        end
    endtask

    // Advance to relative edge 'rel', comparing scoreboard entries as their edges pass
    task automatic step_to(input int rel);
        exp_t e;
        while ((cyc - base) < rel) begin
            @(negedge clock);
            while ((sb.size() > 0) && (sb[0].at <= (cyc - base))) begin
                e = sb.pop_front();
                check_now(e.tag, e.out_n, e.cause);
            end
        end
    endtask

    initial begin
        bus.pll_locked   = 1'b1;
        bus.button_n     = 1'b1;
        bus.sw_reset_req = 1'b0;
        reset_n          = 1'b0;
        repeat (3) @(negedge clock);
        check_now("in_reset", 1'b0, CAUSE_POR);

        reset_n = 1'b1;
        base    = cyc;
        push("por_before", 20, 1'b0, CAUSE_POR);
        push("por_rise",   21, 1'b1, CAUSE_POR);
        step_to(25);

        push("lock_pre",   27, 1'b1, CAUSE_POR);
        push("lock_fall",  28, 1'b0, CAUSE_LOCK);
        push("lock_low",   32, 1'b0, CAUSE_LOCK);
        push("lock_rise",  33, 1'b1, CAUSE_LOCK);
        bus.pll_locked = 1'b0;
        step_to(26);
        bus.pll_locked = 1'b1;
        step_to(40);

        push("bounce_a", 51, 1'b1, CAUSE_LOCK);
        push("bounce_b", 60, 1'b1, CAUSE_LOCK);
        bus.button_n = 1'b0;
        step_to(45);
        bus.button_n = 1'b1;
        step_to(60);

        push("btn_pre",     70,  1'b1, CAUSE_LOCK);
        push("btn_fall",    71,  1'b0, CAUSE_BUTTON);
        push("btn_rel_pre", 104, 1'b0, CAUSE_BUTTON);
        push("btn_rise",    105, 1'b1, CAUSE_BUTTON);
        bus.button_n = 1'b0;
        step_to(90);
        bus.button_n = 1'b1;
        step_to(110);

`ifdef RESET_SEQ_SW_REQ_EN
        push("sw_fall",    111, 1'b0, CAUSE_SW);
        push("sw_extend",  117, 1'b0, CAUSE_SW);
        push("sw_rise",    118, 1'b1, CAUSE_SW);
`else
        push("sw_ignored_a", 111, 1'b1, CAUSE_BUTTON);
        push("sw_ignored_b", 118, 1'b1, CAUSE_BUTTON);
`endif
        bus.sw_reset_req = 1'b1;
        step_to(111);
        bus.sw_reset_req = 1'b0;
        step_to(113);
        bus.sw_reset_req = 1'b1;
        step_to(114);
        bus.sw_reset_req = 1'b0;
        step_to(130);

`ifdef RESET_SEQ_SW_REQ_EN
        push("hold_pre",  140, 1'b1, CAUSE_SW);
`else
        push("hold_pre",  140, 1'b1, CAUSE_BUTTON);
`endif
        push("hold_fall", 141, 1'b0, CAUSE_BUTTON);
        bus.button_n = 1'b0;
        step_to(145);

        #2;
        reset_n = 1'b0;
        #1;
        check_now("async_rst", 1'b0, CAUSE_POR);
        bus.button_n = 1'b1;
        repeat (2) @(negedge clock);

        reset_n = 1'b1;
        base    = cyc;
        push("repor_before", 20, 1'b0, CAUSE_POR);
        push("repor_rise",   21, 1'b1, CAUSE_POR);
        step_to(25);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
